// File: rtl/global_reg_bank.sv
// global_reg_bank: byte-stream loaded shadow registers with atomic commit
// into an active bank. A commit is triggered by a vsync rising edge or by a
// 0xFF command byte. Writes to non-existent registers raise a one-cycle err.
module global_reg_bank #(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      vsync,
  output logic [NUM_REGS*REG_W-1:0] regs_out,
  output logic                      dirty,
  output logic                      err
);

  localparam int BYTES  = REG_W / 8;
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, DATA, WRITE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic               bad;
  logic [CNT_W-1:0]   byte_cnt;
  logic [REG_W-1:0]   asm_word;
  logic               vsync_q;
  logic               accept;
  logic               commit_req;
  logic               write_en;

  assign accept     = in_valid & in_ready;
  // 0xFF is only a command when it arrives as the first byte of a transaction
  assign commit_req = (vsync & ~vsync_q) |
                      (accept && (state == IDLE) && (in_data == 8'hFF));
  assign write_en   = (state == WRITE) && !bad;

  // Command FSM: address byte, little-endian data bytes, one-cycle write slot
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      addr     <= '0;
      bad      <= 1'b0;
      byte_cnt <= '0;
      asm_word <= '0;
      in_ready <= 1'b0;
      err      <= 1'b0;
    end else begin
      err      <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        IDLE: begin
          if (accept && (in_data != 8'hFF)) begin
            byte_cnt <= '0;
            state    <= DATA;
            // an unknown address still consumes its data bytes
            if (int'(in_data) < NUM_REGS) begin
              addr <= in_data[ADDR_W-1:0];
              bad  <= 1'b0;
            end else begin
              bad  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (accept) begin
            for (int k = 0; k < BYTES; k++) begin
              if (byte_cnt == CNT_W'(k)) asm_word[8*k +: 8] <= in_data;
            end
            if (byte_cnt == LAST_BYTE) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              err      <= bad;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // vsync edge detect and dirty tracking; a write wins over a simultaneous commit
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vsync_q <= 1'b0;
      dirty   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (write_en) begin
        dirty <= 1'b1;
      end else if (commit_req) begin
        dirty <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [REG_W-1:0] shadow;
    logic [REG_W-1:0] active;

    // Shadow takes stream writes; active copies the pre-edge shadow on commit
    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (write_en && (addr == ADDR_W'(gi))) shadow <= asm_word;
        if (commit_req) active <= shadow;
      end
    end

    assign regs_out[gi*REG_W +: REG_W] = active;
  end

endmodule

// File: tb/tb_global_reg_bank.sv
// Directed bench for global_reg_bank: default 4x8 instance plus a 3x16 instance.
module tb_global_reg_bank;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        vsync;
  logic [31:0] regs_out;
  logic        dirty;
  logic        err;

  logic        in_valid_b;
  logic        in_ready_b;
  logic        vsync_b;
  logic [47:0] regs_b;
  logic        dirty_b;
  logic        err_b;

  int total  = 0;
  int passed = 0;

  always #5 ACLK = ~ACLK;

  global_reg_bank dut (
    .ACLK(ACLK), .ARESET(ARESET), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .vsync(vsync), .regs_out(regs_out),
    .dirty(dirty), .err(err)
  );

  global_reg_bank #(.NUM_REGS(3), .REG_W(16)) dut16 (
    .ACLK(ACLK), .ARESET(ARESET), .in_data(in_data), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .vsync(vsync_b), .regs_out(regs_b),
    .dirty(dirty_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one byte to the selected instance and wait until it is taken
  task automatic send(input logic sel, input logic [7:0] b);
    int n = 0;
    @(negedge ACLK);
    in_data = b;
    if (sel) in_valid_b = 1'b1;
    else     in_valid   = 1'b1;
    while (((sel ? in_ready_b : in_ready) == 1'b0) && (n < 20)) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 20) begin
      total++;
      $display("FAIL send_timeout: byte 0x%02h not accepted after %0d cycles, required < 20", b, n);
    end
    @(posedge ACLK);
    #1;
    in_valid   = 1'b0;
    in_valid_b = 1'b0;
    $display("tx dut%0d byte 0x%02h", sel ? 16 : 8, b);
  endtask

  task automatic vsync_pulse();
    @(negedge ACLK);
    vsync = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1; in_data = 8'h00; in_valid = 1'b0; vsync = 1'b0;
    in_valid_b = 1'b0; vsync_b = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_regs", regs_out, 0);
    check("rst_dirty", dirty, 0);
    check("rst_err", err, 0);
    check("rst_regs16", regs_b, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    check("ready_after_rst", in_ready, 1);

    // Basic write to reg 2 then vsync commit
    send(0, 8'h02);
    send(0, 8'h5A);
    check("write_slot_ready", in_ready, 0);
    check("write_slot_dirty", dirty, 0);
    @(posedge ACLK);
    #1;
    check("dirty_after_write", dirty, 1);
    check("ready_after_write", in_ready, 1);
    check("no_commit_yet", regs_out, 32'h0);
    vsync_pulse();
    check("vsync_commit", regs_out, 32'h005A_0000);
    check("dirty_cleared", dirty, 0);
    @(negedge ACLK);
    vsync = 1'b0;

    // Bad address: err one cycle, nothing written
    send(0, 8'h07);
    send(0, 8'h33);
    check("err_pulse", err, 1);
    @(posedge ACLK);
    #1;
    check("err_one_cycle", err, 0);
    check("bad_no_dirty", dirty, 0);
    check("bad_no_change", regs_out, 32'h005A_0000);
    send(0, 8'h00);
    send(0, 8'h77);
    @(posedge ACLK);
    #1;
    check("addr0_dirty", dirty, 1);
    send(0, 8'hFF);
    check("ff_commit", regs_out, 32'h005A_0077);
    check("ff_dirty", dirty, 0);

    // Commit on the same edge as a WRITE takes the pre-write shadow
    send(0, 8'h00);
    send(0, 8'hAA);
    vsync_pulse();
    check("coinc_old_value", regs_out, 32'h005A_0077);
    check("coinc_dirty", dirty, 1);
    @(negedge ACLK);
    vsync = 1'b0;
    vsync_pulse();
    check("coinc_next_commit", regs_out, 32'h005A_00AA);
    check("coinc_dirty_clear", dirty, 0);
    @(negedge ACLK);
    vsync = 1'b0;

    // Reset mid-transaction discards the partial write
    send(0, 8'h01);
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    check("midrst_regs", regs_out, 32'h0);
    check("midrst_ready", in_ready, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    send(0, 8'h02);
    send(0, 8'h11);
    send(0, 8'hFF);
    check("midrst_commit", regs_out, 32'h0011_0000);
    check("midrst_reg1", regs_out[15:8], 8'h00);

    // Held vsync commits once: a write during the hold stays uncommitted
    @(negedge ACLK);
    vsync = 1'b1;
    send(0, 8'h03);
    send(0, 8'h44);
    repeat (3) @(posedge ACLK);
    #1;
    check("held_vsync_once", regs_out, 32'h0011_0000);
    check("held_vsync_dirty", dirty, 1);
    @(negedge ACLK);
    vsync = 1'b0;

    // 16-bit registers, little-endian assembly, 0xFF commit
    send(1, 8'h01);
    send(1, 8'h34);
    send(1, 8'h12);
    send(1, 8'hFF);
    check("w16_commit", regs_b, 48'h0000_1234_0000);
    check("w16_dirty", dirty_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/global_reg_bank.md
GLOBAL_REG_BANK -- requirements
Module: global_reg_bank

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, number of registers (1..255).
REQ-002 The block SHALL have parameter REG_W, default 8, register width in bits (8, 16, 24 or 32).
REQ-003 The block SHALL derive local BYTES = REG_W/8 and ADDR_W = max(1, clog2(NUM_REGS)).
REQ-004 The block SHALL have one clock and one reset: port ACLK (input, 1) and port ARESET (input, 1); reset is asynchronous and active-high.
REQ-005 The block SHALL have port in_data (input, 8): byte stream of commands and data.
REQ-006 The block SHALL have port in_valid (input, 1): in_data valid.
REQ-007 The block SHALL have port in_ready (output, 1): block accepts a byte.
REQ-008 The block SHALL have port vsync (input, 1): frame-sync commit strobe, synchronous to ACLK.
REQ-009 The block SHALL have port regs_out (output, NUM_REGS*REG_W): active registers, reg i at [i*REG_W +: REG_W].
REQ-010 The block SHALL have port dirty (output, 1): shadow holds data not yet committed.
REQ-011 The block SHALL have port err (output, 1): one-cycle pulse when a write addressed a non-existent register.

Function
REQ-012 A byte SHALL transfer on a rising ACLK edge with in_valid=1 and in_ready=1; in_data SHALL be ignored otherwise.
REQ-013 The block SHALL hold two register arrays: shadow[NUM_REGS] (written by the stream) and active[NUM_REGS] (driving regs_out), each REG_W wide.
REQ-014 The FSM SHALL have states IDLE, DATA and WRITE; in_ready=1 in IDLE and DATA, 0 in WRITE.
REQ-015 In IDLE, a byte 0xFF SHALL be a commit command; the FSM stays in IDLE.
REQ-016 In IDLE, a byte < NUM_REGS SHALL latch the address, clear the byte counter and move to DATA.
REQ-017 In IDLE, any other byte SHALL set an internal bad flag and move to DATA, so the data bytes are still consumed.
REQ-018 In DATA, byte k (k=0..BYTES-1) SHALL load bits [8k+7:8k] of an assembly register (little-endian); after byte BYTES-1 the FSM SHALL move to WRITE.
REQ-019 WRITE SHALL last exactly one cycle: if the address is valid, shadow[addr] <= assembly and dirty <= 1; if bad, err=1 for that cycle and no array changes; next state IDLE.
REQ-020 Latency: last data byte accepted at edge N; shadow updated at edge N+1; in_ready=1 again from edge N+1 onward (state IDLE).
REQ-021 commit_req SHALL be (vsync & ~vsync_q) | (0xFF accepted in IDLE), where vsync_q is vsync registered.
REQ-022 On an edge with commit_req=1, all active[i] <= shadow[i] atomically, dirty <= 0, and regs_out reflects the new values after that edge.
REQ-023 If vsync is held high for several cycles, it SHALL produce one commit only.
REQ-024 If commit and a WRITE occur on the same edge, active SHALL take the pre-write shadow and dirty SHALL remain 1.
REQ-025 A commit SHALL NOT disturb the FSM, the byte counter or the assembly register.
REQ-026 Registers not written since the last commit SHALL re-commit their unchanged shadow values.

Reset
REQ-027 While ARESET=1: shadow and active all 0; regs_out=0; FSM IDLE; byte counter 0; dirty=0; err=0; vsync_q=0; in_ready=0.
REQ-028 After ARESET deasserts, in_ready SHALL be 1 on the first ACLK edge.
REQ-029 Reset asserted mid-transaction SHALL discard the partial transaction without writing any array.

Verification
REQ-030 Defaults; stream 0x02,0x5A, then vsync pulse -> dirty=1 after WRITE; regs_out[23:16]=0x5A one cycle after vsync edge; dirty=0.
REQ-031 Defaults; stream 0x07,0x33 -> err pulses exactly one cycle, no array change, dirty stays 0, next byte 0x00 is accepted as an address.
REQ-032 REG_W=16, NUM_REGS=3; stream 0x01,0x34,0x12,0xFF -> regs_out[31:16]=0x1234 after the 0xFF edge, with no vsync.
REQ-033 Defaults; vsync rises on the same edge as the WRITE for 0x00,0xAA -> regs_out[7:0] keeps its old value, dirty=1; next vsync -> 0xAA.
REQ-034 Defaults; ARESET pulses after 0x01 is accepted, then stream 0x02,0x11,0xFF -> only regs_out[23:16]=0x11; reg 1 = 0; vsync held 5 cycles -> one commit.
